// File: rtl/piano_key_debounce.sv
// -----------------------------------------------------------------------------
// piano_key_debounce
//
// Front-end conditioning for the 13-key piano. Raw active-low buttons are
// synchronized, debounced per key, priority-resolved and presented as a clean
// active-low key vector for the tone-select stage, plus a key index and a
// one-cycle press pulse for status display.
//
// Optional feature macro: PIANO_KEY_LOCK_EN
//   defined   : single-key lock FSM (IDLE/HELD); key_out has at most one bit low
//   undefined : key_out follows the debounced vector, chords pass through
//
// Parameters
//   DEBOUNCE_CYCLES : clk cycles a changed input must stay steady before it is
//                     accepted (>= 2). Default 240000 = 20 ms at 12 MHz.
//
// Ports
//   clk         : system clock
//   rst         : asynchronous active-high reset
//   key_raw     : raw buttons, active-low, bit 12 = C4 ... bit 0 = C5
//   key_out     : debounced (optionally locked) vector, active-low, same order
//   key_idx     : bit number of the reported key, 4'hF when none
//   press_pulse : one cycle high when a new key first appears on key_out
// -----------------------------------------------------------------------------
module piano_key_debounce #(
  parameter int DEBOUNCE_CYCLES = 240000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [12:0] key_raw,
  output logic [12:0] key_out,
  output logic [3:0]  key_idx,
  output logic        press_pulse
);

  localparam int            NKEYS    = 13;
  localparam int            CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]    IDX_NONE = 4'hF;

  // ---------------------------------------------------------------------------
  // Two-flop synchronizer. Reset to 1 so every key starts out released.
  // ---------------------------------------------------------------------------
  logic [NKEYS-1:0] r_sync1;
  logic [NKEYS-1:0] r_sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= key_raw;
      r_sync2 <= r_sync1;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-key debounce. The counter runs only while the synchronized input
  // disagrees with the accepted level; any return to the accepted level clears
  // it, so only DEBOUNCE_CYCLES consecutive disagreeing samples flip the key.
  // ---------------------------------------------------------------------------
  logic [NKEYS-1:0] w_stable;

  genvar gi;
  generate
    for (gi = 0; gi < NKEYS; gi++) begin : g_key
      logic [CW-1:0] r_cnt;
      logic          r_stable;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_cnt    <= '0;
          r_stable <= 1'b1;
        end else if (r_sync2[gi] == r_stable) begin
          r_cnt <= '0;
        end else if (r_cnt == CNT_MAX) begin
          r_stable <= r_sync2[gi];
          r_cnt    <= '0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end

      assign w_stable[gi] = r_stable;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Priority encoder: highest pressed bit number wins (C4 over C5).
  // Ascending scan so the last match, the highest bit, is kept.
  // ---------------------------------------------------------------------------
  logic [3:0] w_winner;

  always_comb begin
    w_winner = IDX_NONE;
    for (int i = 0; i < NKEYS; i++) begin
      if (!w_stable[i]) begin
        w_winner = 4'(i);
      end
    end
  end

  // Next values for the registered outputs, produced by either mode below.
  logic [NKEYS-1:0] w_key_out_next;
  logic [3:0]       w_key_idx_next;
  logic             w_pulse_next;

  logic [NKEYS-1:0] r_key_out;
  logic [3:0]       r_key_idx;
  logic             r_press_pulse;

`ifdef PIANO_KEY_LOCK_EN
  // ---------------------------------------------------------------------------
  // Single-key lock. The first winner is latched and reported until that very
  // key is released; other keys are ignored meanwhile. A release always shows
  // one all-released cycle before another still-held key is captured.
  // ---------------------------------------------------------------------------
  typedef enum logic {
    S_IDLE = 1'b0,
    S_HELD = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [3:0]       r_held_idx;
  logic [3:0]       w_held_idx_next;
  logic [NKEYS-1:0] r_held_mask;
  logic [NKEYS-1:0] w_held_mask_next;
  logic [NKEYS-1:0] w_winner_mask;
  logic             w_any_pressed;
  logic             w_held_released;

  assign w_any_pressed   = ~&w_stable;
  // A winner of 4'hF shifts the bit out entirely; only used when a key is down.
  assign w_winner_mask   = NKEYS'(1) << w_winner;
  assign w_held_released = |(r_held_mask & w_stable);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_held_idx  <= IDX_NONE;
      r_held_mask <= '0;
    end else begin
      r_state     <= w_state_next;
      r_held_idx  <= w_held_idx_next;
      r_held_mask <= w_held_mask_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next     = r_state;
    w_held_idx_next  = r_held_idx;
    w_held_mask_next = r_held_mask;
    case (r_state)
      S_IDLE: begin
        if (w_any_pressed) begin
          w_state_next     = S_HELD;
          w_held_idx_next  = w_winner;
          w_held_mask_next = w_winner_mask;
        end
      end
      S_HELD: begin
        if (w_held_released) begin
          w_state_next     = S_IDLE;
          w_held_idx_next  = IDX_NONE;
          w_held_mask_next = '0;
        end
      end
      default: begin
        w_state_next     = S_IDLE;
        w_held_idx_next  = IDX_NONE;
        w_held_mask_next = '0;
      end
    endcase
  end

  // Output logic: values registered on the same edge as the state change, so
  // the captured key and its pulse appear together.
  always_comb begin
    w_key_out_next = '1;
    w_key_idx_next = IDX_NONE;
    w_pulse_next   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any_pressed) begin
          w_key_out_next = ~w_winner_mask;
          w_key_idx_next = w_winner;
          w_pulse_next   = 1'b1;
        end
      end
      S_HELD: begin
        if (!w_held_released) begin
          w_key_out_next = ~r_held_mask;
          w_key_idx_next = r_held_idx;
        end
      end
      default: begin
        w_key_out_next = '1;
      end
    endcase
  end
`else
  // ---------------------------------------------------------------------------
  // Pass-through mode: the debounced vector is reported as is. r_key_out holds
  // last cycle's debounced vector, so a 1 there with a 0 now is a new press.
  // ---------------------------------------------------------------------------
  assign w_key_out_next = w_stable;
  assign w_key_idx_next = w_winner;
  assign w_pulse_next   = |(r_key_out & ~w_stable);
`endif

  // ---------------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_key_out     <= '1;
      r_key_idx     <= IDX_NONE;
      r_press_pulse <= 1'b0;
    end else begin
      r_key_out     <= w_key_out_next;
      r_key_idx     <= w_key_idx_next;
      r_press_pulse <= w_pulse_next;
    end
  end

  assign key_out     = r_key_out;
  assign key_idx     = r_key_idx;
  assign press_pulse = r_press_pulse;

endmodule

// File: tb/tb_piano_key_debounce.sv
// -----------------------------------------------------------------------------
// tb_piano_key_debounce
//
// Directed scenarios plus random key patterns, every cycle compared with a
// behavioural model: keys are accepted after DEB consecutive samples that
// disagree with the accepted level, seen through a two-sample delay.
// Works with or without PIANO_KEY_LOCK_EN defined.
// -----------------------------------------------------------------------------
module tb_piano_key_debounce;

  localparam int DEB = 8;

  logic        clk;
  logic        rst;
  logic [12:0] key_raw;
  logic [12:0] key_out;
  logic [3:0]  key_idx;
  logic        press_pulse;

  piano_key_debounce #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk         (clk),
    .rst         (rst),
    .key_raw     (key_raw),
    .key_out     (key_out),
    .key_idx     (key_idx),
    .press_pulse (press_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_fail;
  int pulse_cnt;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [12:0] m_d1, m_d2;      // raw input delayed by one and two samples
  logic [12:0] m_stable;        // accepted key levels
  logic [12:0] m_prev_stable;
  logic [12:0] m_out;
  logic [3:0]  m_idx;
  logic        m_pulse;
  int          m_run [13];      // consecutive disagreeing samples per key
  int          m_held;          // locked key, -1 when none

  function automatic int top_pressed(input logic [12:0] s);
    for (int i = 12; i >= 0; i--) begin
      if (s[i] == 1'b0) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_d1 = '1; m_d2 = '1; m_stable = '1; m_prev_stable = '1;
    m_out = '1; m_idx = 4'hF; m_pulse = 1'b0; m_held = -1;
    for (int i = 0; i < 13; i++) m_run[i] = 0;
  endtask

  always @(posedge clk or posedge rst) begin : model
    int w;
    if (rst) begin
      model_reset();
    end else begin
      // outputs follow the accepted levels as they stood before this edge
      w = top_pressed(m_stable);
`ifdef PIANO_KEY_LOCK_EN
      m_pulse = 1'b0;
      if (m_held < 0) begin
        if (w >= 0) begin
          m_held  = w;
          m_out   = 13'h1FFF ^ (13'd1 << w);
          m_idx   = 4'(w);
          m_pulse = 1'b1;
        end else begin
          m_out = 13'h1FFF;
          m_idx = 4'hF;
        end
      end else if (m_stable[m_held] == 1'b1) begin
        m_held = -1;
        m_out  = 13'h1FFF;
        m_idx  = 4'hF;
      end
`else
      m_pulse       = ((m_prev_stable & ~m_stable) != 13'h0);
      m_prev_stable = m_stable;
      m_out         = m_stable;
      m_idx         = (w < 0) ? 4'hF : 4'(w);
`endif
      for (int i = 0; i < 13; i++) begin
        if (m_d2[i] != m_stable[i]) begin
          m_run[i]++;
          if (m_run[i] == DEB) begin
            m_stable[i] = m_d2[i];
            m_run[i]    = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_d2 = m_d1;
      m_d1 = key_raw;
    end
  end

  // ---------------------------------------------------------------------------
  // Checking helpers
  // ---------------------------------------------------------------------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock; outputs sampled on the falling edge and compared with the model
  task automatic step();
    @(negedge clk);
    chk("key_out", 32'(key_out), 32'(m_out));
    chk("key_idx", 32'(key_idx), 32'(m_idx));
    chk("press_pulse", 32'(press_pulse), 32'(m_pulse));
    if (press_pulse === 1'b1) pulse_cnt++;
  endtask

  // edges until key_out equals target; -1 if the bound expires
  task automatic wait_out(input logic [12:0] target, input int limit, output int edges);
    edges = -1;
    for (int k = 1; k <= limit; k++) begin
      step();
      if (key_out === target) begin
        edges = k;
        break;
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int e;
    logic [12:0] pat;
    n_checks  = 0;
    n_fail    = 0;
    pulse_cnt = 0;
    rst       = 1'b1;
    key_raw   = 13'h1FFF;

    // reset
    repeat (3) step();
    chk("rst_key_out", 32'(key_out), 32'h1FFF);
    chk("rst_key_idx", 32'(key_idx), 32'hF);
    chk("rst_pulse", 32'(press_pulse), 32'h0);
    rst = 1'b0;
    for (int c = 0; c < 50; c++) begin
      step();
      chk("idle_hold", 32'(key_out), 32'h1FFF);
    end

    // clean press / release of E4
    pulse_cnt  = 0;
    key_raw[8] = 1'b0;
    wait_out(13'h1EFF, 40, e);
    chk("press_latency", 32'(e), 32'd11);
    chk("press_idx", 32'(key_idx), 32'd8);
    repeat (3) step();
    chk("press_pulses", 32'(pulse_cnt), 32'd1);
    key_raw[8] = 1'b1;
    wait_out(13'h1FFF, 40, e);
    chk("release_latency", 32'(e), 32'd11);
    repeat (3) step();

    // bounce on A4: 5 low / 2 high, ending high, then hold low
    pulse_cnt = 0;
    for (int c = 0; c < 42; c++) begin
      key_raw[3] = ((c % 7) < 5) ? 1'b0 : 1'b1;
      step();
      chk("bounce_quiet", 32'(key_out), 32'h1FFF);
    end
    key_raw[3] = 1'b0;
    wait_out(13'h1FF7, 40, e);
    chk("bounce_latency", 32'(e), 32'd11);
    repeat (3) step();
    chk("bounce_pulses", 32'(pulse_cnt), 32'd1);

    // A4 held, D4 added 20 cycles later, then A4 released
    repeat (20) step();
    key_raw[10] = 1'b0;
    repeat (15) step();
`ifdef PIANO_KEY_LOCK_EN
    chk("lock_hold", 32'(key_out), 32'h1FF7);
    key_raw[3] = 1'b1;
    wait_out(13'h1FFF, 40, e);
    chk("lock_release_latency", 32'(e), 32'd11);
    pulse_cnt = 0;
    step();
    chk("lock_recapture", 32'(key_out), 32'h1BFF);
    chk("lock_recapture_idx", 32'(key_idx), 32'd10);
    chk("lock_recapture_pulse", 32'(pulse_cnt), 32'd1);
`else
    chk("chord_hold", 32'(key_out), 32'h1BF7);
    chk("chord_idx", 32'(key_idx), 32'd10);
    key_raw[3] = 1'b1;
    wait_out(13'h1BFF, 40, e);
    chk("chord_release_latency", 32'(e), 32'd11);
    chk("chord_release_idx", 32'(key_idx), 32'd10);
`endif
    key_raw = 13'h1FFF;
    repeat (15) step();

    // simultaneous C4 + C5
    pulse_cnt   = 0;
    key_raw[12] = 1'b0;
    key_raw[0]  = 1'b0;
`ifdef PIANO_KEY_LOCK_EN
    wait_out(13'h0FFF, 40, e);
`else
    wait_out(13'h0FFE, 40, e);
`endif
    chk("simul_latency", 32'(e), 32'd11);
    chk("simul_idx", 32'(key_idx), 32'd12);
    repeat (3) step();
    chk("simul_pulses", 32'(pulse_cnt), 32'd1);
    key_raw = 13'h1FFF;
    repeat (15) step();

    // reset in the middle of a debounce count on G4
    key_raw[5] = 1'b0;
    repeat (6) step();
    rst = 1'b1;
    step();
    step();
    chk("midrst_key_out", 32'(key_out), 32'h1FFF);
    rst = 1'b0;
    wait_out(13'h1FDF, 40, e);
    chk("midrst_latency", 32'(e), 32'd11);
    key_raw = 13'h1FFF;
    repeat (15) step();

    // random sparse key patterns with random hold times
    for (int s = 0; s < 60; s++) begin
      pat     = 13'($urandom) & 13'($urandom) & 13'($urandom);
      key_raw = ~pat;
      repeat ($urandom_range(1, 16)) step();
    end
    key_raw = 13'h1FFF;
    repeat (20) step();
    chk("final_idle", 32'(key_out), 32'h1FFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
